// File: rtl/ddr_arbit_pkg.sv
// ddr_arbit_pkg
//   Shared definitions for the DDR command arbiter.
//   - arb_state_t : one-hot FSM state encoding (IDLE, ARBIT, GRANT, WAIT_END)
//   - req_index   : (channel, direction) -> flat requestor index
//   - index_is_wr : flat requestor index -> 1 for a write requestor
//   - index_to_ch : flat requestor index -> channel number
//   Requestor numbering: 0..NCH-1 are the write channels,
//   NCH..2*NCH-1 are the read channels (channel = index - NCH).
package ddr_arbit_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0001,
        ST_ARBIT    = 4'b0010,
        ST_GRANT    = 4'b0100,
        ST_WAIT_END = 4'b1000
    } arb_state_t;

    function automatic int req_index(input int ch, input logic is_wr, input int nch);
        return is_wr ? ch : nch + ch;
    endfunction

    function automatic logic index_is_wr(input int idx, input int nch);
        return idx < nch;
    endfunction

    function automatic int index_to_ch(input int idx, input int nch);
        return (idx < nch) ? idx : idx - nch;
    endfunction

endpackage

// File: rtl/ddr_arbit_rr_pick.sv
// rr_pick
//   Combinational round-robin search over an N-bit request vector.
//   The search starts one position after the last granted index and
//   wraps around, so the most recently served requestor is tried last.
//   Ports:
//     req   in  N   request vector
//     last  in  IW  index granted most recently
//     found out 1   at least one request is set
//     idx   out IW  winning index (0 when found is low)
module rr_pick #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] probe;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        probe = '0;
        for (int k = 1; k <= N; k++) begin
            probe = IW'((int'(last) + k) % N);
            if (!found && req[probe]) begin
                found = 1'b1;
                idx   = probe;
            end
        end
    end

endmodule

// File: rtl/ddr_arbit_rr.sv
// ddr_arbit_rr
//   Round-robin arbiter granting one DDR command at a time among NCH
//   channels, each with a write and a read requestor.
//   Optional feature: define ARBIT_WR_PRIO_EN so that any pending write
//   beats all reads (round-robin kept separately inside each group).
//   Without it a single round-robin runs over all 2*NCH requestors.
//
//   Handshake: wr_req/rd_req may be levels or single-cycle pulses; any
//   high cycle latches a pending flag that is only consumed when the
//   requestor is granted. A grant is announced by a one-cycle one-hot
//   wr_cmd_start/rd_cmd_start pulse; the transfer is finished by the end
//   input of the granted direction, which counts only while waiting
//   (never in the grant cycle itself). A watchdog (TO_CYC cycles, 0 = off)
//   abandons a transfer whose end never comes and pulses timeout_err.
//
//   Ports:
//     sclk          in   1     clock
//     rst_n         in   1     asynchronous active-low reset
//     wr_req        in   NCH   per-channel write request
//     rd_req        in   NCH   per-channel read request
//     wr_end        in   1     write command finished
//     rd_end        in   1     read command finished
//     wr_cmd_start  out  NCH   one-cycle write start, one-hot
//     rd_cmd_start  out  NCH   one-cycle read start, one-hot
//     gnt_ch        out  CH_W  granted channel
//     gnt_wr        out  1     granted direction, 1 = write
//     busy          out  1     high in GRANT or WAIT_END
//     timeout_err   out  1     one-cycle watchdog expiry pulse
module ddr_arbit_rr
    import ddr_arbit_pkg::*;
#(
    parameter int  NCH    = 2,
    parameter int  TO_CYC = 1024,
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            sclk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  wr_req,
    input  logic [NCH-1:0]  rd_req,
    input  logic            wr_end,
    input  logic            rd_end,
    output logic [NCH-1:0]  wr_cmd_start,
    output logic [NCH-1:0]  rd_cmd_start,
    output logic [CH_W-1:0] gnt_ch,
    output logic            gnt_wr,
    output logic            busy,
    output logic            timeout_err
);

    localparam int NREQ  = 2 * NCH;
    localparam int IDX_W = $clog2(NREQ);
    localparam int WD_W  = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    arb_state_t       state;
    arb_state_t       state_d;
    logic [NREQ-1:0]  pend;
    logic [NREQ-1:0]  req_vec;
    logic [NREQ-1:0]  clr_vec;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [CH_W-1:0]  win_ch;
    logic             win_wr;
    logic             grant_entry;
    logic             end_sel;
    logic             wd_hit;
    logic             timeout_d;
    logic [WD_W-1:0]  wd_cnt;

    // ---------------------------------------------------------------
    // Winner selection
    // ---------------------------------------------------------------
`ifdef ARBIT_WR_PRIO_EN
    logic [CH_W-1:0] last_wr;
    logic [CH_W-1:0] last_rd;
    logic [CH_W-1:0] wr_idx;
    logic [CH_W-1:0] rd_idx;
    logic            wr_found;
    logic            rd_found;

    rr_pick #(.N(NCH)) u_pick_wr (
        .req   (pend[NCH-1:0]),
        .last  (last_wr),
        .found (wr_found),
        .idx   (wr_idx)
    );

    rr_pick #(.N(NCH)) u_pick_rd (
        .req   (pend[NREQ-1:NCH]),
        .last  (last_rd),
        .found (rd_found),
        .idx   (rd_idx)
    );

    always_comb begin
        win_found = wr_found | rd_found;
        win_wr    = wr_found;
        win_ch    = wr_found ? wr_idx : rd_idx;
        win_idx   = IDX_W'(req_index(int'(win_ch), win_wr, NCH));
    end

    // Each group remembers its own last winner; both start so that
    // channel 0 is tried first.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr <= CH_W'(NCH - 1);
            last_rd <= CH_W'(NCH - 1);
        end else if (grant_entry) begin
            if (win_wr) last_wr <= win_ch;
            else        last_rd <= win_ch;
        end
    end
`else
    logic [IDX_W-1:0] last_grant;

    rr_pick #(.N(NREQ)) u_pick (
        .req   (pend),
        .last  (last_grant),
        .found (win_found),
        .idx   (win_idx)
    );

    always_comb begin
        win_wr = index_is_wr(int'(win_idx), NCH);
        win_ch = CH_W'(index_to_ch(int'(win_idx), NCH));
    end

    // Starting at 2*NCH-1 makes requestor 0 the first one searched.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n)           last_grant <= IDX_W'(NREQ - 1);
        else if (grant_entry) last_grant <= win_idx;
    end
`endif

    // ---------------------------------------------------------------
    // Pending flags: a grant consumes the flag even if the requestor is
    // still asserting in that cycle; a later request re-arms it.
    // ---------------------------------------------------------------
    assign req_vec     = {rd_req, wr_req};
    assign grant_entry = (state == ST_ARBIT) && win_found;

    always_comb begin
        clr_vec = '0;
        if (grant_entry) clr_vec = NREQ'(1) << win_idx;
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= (pend | req_vec) & ~clr_vec;
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    assign end_sel = gnt_wr ? wr_end : rd_end;
    assign wd_hit  = (TO_CYC != 0) && (wd_cnt == WD_W'(TO_CYC - 1));

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        timeout_d = 1'b0;
        case (state)
            ST_IDLE:     state_d = ST_ARBIT;
            ST_ARBIT:    if (win_found) state_d = ST_GRANT;
            ST_GRANT:    state_d = ST_WAIT_END;
            ST_WAIT_END: begin
                if (end_sel) begin
                    state_d = ST_ARBIT;
                end else if (wd_hit) begin
                    state_d   = ST_ARBIT;
                    timeout_d = 1'b1;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // Watchdog: zero on the first WAIT_END cycle, +1 per waiting cycle.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == ST_GRANT) begin
            wd_cnt <= '0;
        end else if ((TO_CYC != 0) && (state == ST_WAIT_END)) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign busy = (state == ST_GRANT) || (state == ST_WAIT_END);

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_ch       <= '0;
            gnt_wr       <= 1'b0;
            wr_cmd_start <= '0;
            rd_cmd_start <= '0;
            timeout_err  <= 1'b0;
        end else begin
            if (grant_entry) begin
                gnt_ch <= win_ch;
                gnt_wr <= win_wr;
            end
            // Start is registered off GRANT, so it lands on the first
            // WAIT_END cycle and can never overlap a second grant.
            wr_cmd_start <= '0;
            rd_cmd_start <= '0;
            if (state == ST_GRANT) begin
                if (gnt_wr) wr_cmd_start <= NCH'(1) << gnt_ch;
                else        rd_cmd_start <= NCH'(1) << gnt_ch;
            end
            timeout_err <= timeout_d;
        end
    end

endmodule

// File: tb/tb_ddr_arbit_rr.sv
module tb_ddr_arbit_rr;

  localparam int NCH    = 2;
  localparam int TO_CYC = 16;
  localparam int CH_W   = 1;
  localparam int NREQ   = 2 * NCH;

  // ---------------- clock / reset ----------------
  logic            sclk  = 1'b0;
  logic            rst_n = 1'b0;
  logic [NCH-1:0]  wr_req = '0;
  logic [NCH-1:0]  rd_req = '0;
  logic            wr_end = 1'b0;
  logic            rd_end = 1'b0;
  logic [NCH-1:0]  wr_cmd_start;
  logic [NCH-1:0]  rd_cmd_start;
  logic [CH_W-1:0] gnt_ch;
  logic            gnt_wr;
  logic            busy;
  logic            timeout_err;

  always #5 sclk = ~sclk;

  ddr_arbit_rr #(.NCH(NCH), .TO_CYC(TO_CYC)) dut (
    .sclk         (sclk),
    .rst_n        (rst_n),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .wr_end       (wr_end),
    .rd_end       (rd_end),
    .wr_cmd_start (wr_cmd_start),
    .rd_cmd_start (rd_cmd_start),
    .gnt_ch       (gnt_ch),
    .gnt_wr       (gnt_wr),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction-timeline model: a winner picked in cycle a starts in a+2,
  // busy covers a+1 up to the cycle its end is seen, and the next pick
  // can happen the cycle after release.
  bit         m_pend[NREQ];
  int         m_last, m_last_w, m_last_r;
  bit         m_own;
  int         m_a, m_win, m_arb_from, m_to_at, m_gch;
  bit         m_gwr;
  logic [3:0] exp_q[$];

  int glog[$];
  int tgap_q[$];
  int last_start_c;
  int mcyc;

  // responder (memory side)
  int resp_cnt  = 0;
  bit resp_wr   = 1'b0;
  bit resp_en   = 1'b0;
  int resp_dly  = 3;
  bit rand_resp = 1'b0;

  function automatic void model_reset();
    for (int i = 0; i < NREQ; i++) m_pend[i] = 1'b0;
    m_last     = NREQ - 1;
    m_last_w   = NCH - 1;
    m_last_r   = NCH - 1;
    m_own      = 1'b0;
    m_a        = -10;
    m_win      = 0;
    m_arb_from = 1;
    m_to_at    = -1;
    m_gch      = 0;
    m_gwr      = 1'b0;
    exp_q.delete();
  endfunction

  // search n flags starting at m_pend[lo], first candidate after 'last'
  function automatic int rr_search(input int lo, input int n, input int last);
    for (int k = 1; k <= n; k++) begin
      int j;
      j = (last + k) % n;
      if (m_pend[lo + j]) return j;
    end
    return -1;
  endfunction

  function automatic bit req_bit(input int i);
    return (i < NCH) ? wr_req[i] : rd_req[i - NCH];
  endfunction

  function automatic void model_advance(input int c);
    bit picked;
    int j;
    picked = 1'b0;
    if (m_own && c >= m_a + 2) begin
      if (m_gwr ? wr_end : rd_end) begin
        m_own = 1'b0; m_arb_from = c + 1;
      end else if (TO_CYC > 0 && c == m_a + 2 + TO_CYC - 1) begin
        m_own = 1'b0; m_arb_from = c + 1; m_to_at = c + 1;
      end
    end
    if (!m_own && c >= m_arb_from) begin
`ifdef ARBIT_WR_PRIO_EN
      j = rr_search(0, NCH, m_last_w);
      if (j >= 0) begin
        m_win = j; m_last_w = j; picked = 1'b1;
      end else begin
        j = rr_search(NCH, NCH, m_last_r);
        if (j >= 0) begin
          m_win = NCH + j; m_last_r = j; picked = 1'b1;
        end
      end
`else
      j = rr_search(0, NREQ, m_last);
      if (j >= 0) begin
        m_win = j; m_last = j; picked = 1'b1;
      end
`endif
      if (picked) begin
        m_own = 1'b1;
        m_a   = c;
        m_gwr = (m_win < NCH);
        m_gch = (m_win < NCH) ? m_win : m_win - NCH;
        exp_q.push_back(4'(m_win));
      end
    end
    for (int i = 0; i < NREQ; i++) m_pend[i] = m_pend[i] | req_bit(i);
    if (picked) m_pend[m_win] = 1'b0;
  endfunction

  task automatic monitor_cycle(input int c);
    logic [NCH-1:0] e_wr, e_rd;
    logic           e_busy, e_to;
    int             idx;
    e_wr = '0;
    e_rd = '0;
    if (m_own && c == m_a + 2) begin
      if (m_win < NCH) e_wr[m_win] = 1'b1;
      else             e_rd[m_win - NCH] = 1'b1;
    end
    e_busy = m_own && (c >= m_a + 1);
    e_to   = (c == m_to_at);
    check("outs", {wr_cmd_start, rd_cmd_start, gnt_ch, gnt_wr, busy, timeout_err},
                  {e_wr, e_rd, CH_W'(m_gch), m_gwr, e_busy, e_to});
    check("onehot", 32'($countones({wr_cmd_start, rd_cmd_start}) <= 1), 1);
    if (|{wr_cmd_start, rd_cmd_start}) begin
      idx = 0;
      for (int i = 0; i < NCH; i++) begin
        if (wr_cmd_start[i]) idx = i;
        if (rd_cmd_start[i]) idx = NCH + i;
      end
      glog.push_back(idx);
      last_start_c = c;
      check("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("sb_grant", idx, 32'(exp_q.pop_front()));
      if (resp_en && !(rand_resp && $urandom_range(0, 7) == 0)) begin
        resp_cnt = rand_resp ? int'($urandom_range(1, 6)) : resp_dly;
        resp_wr  = (idx < NCH);
      end
    end
    if (timeout_err) tgap_q.push_back(c - last_start_c);
    model_advance(c);
  endtask

  always @(negedge sclk) begin
    if (!rst_n) begin
      check("rst_out", {wr_cmd_start, rd_cmd_start, gnt_ch, gnt_wr, busy, timeout_err}, 0);
      model_reset();
      mcyc = 0;
    end else begin
      monitor_cycle(mcyc);
      mcyc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input logic [NCH-1:0] wq, input logic [NCH-1:0] rq,
                      input logic we, input logic re);
    logic e_pulse;
    @(posedge sclk);
    #1;
    e_pulse = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) e_pulse = 1'b1;
    end
    wr_req = wq;
    rd_req = rq;
    wr_end = we | (e_pulse & resp_wr);
    rd_end = re | (e_pulse & ~resp_wr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, '0, 1'b0, 1'b0);
  endtask

  task automatic reset_dut();
    @(posedge sclk);
    #1;
    rst_n = 1'b0; wr_req = '0; rd_req = '0; wr_end = 1'b0; rd_end = 1'b0;
    resp_cnt = 0;
    repeat (2) @(posedge sclk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int             exp_ord[5];
  int             nrd;
  logic [NCH-1:0] wq, rq;

  initial begin
`ifdef ARBIT_WR_PRIO_EN
    exp_ord = '{0, 1, 0, 1, 0};
`else
    exp_ord = '{0, 1, 2, 3, 0};
`endif
    repeat (3) @(posedge sclk);
    #1 rst_n = 1'b1;

    // single write pulse on channel 0
    resp_en = 1'b1; resp_dly = 3; glog.delete();
    tick(2'b01, 2'b00, 1'b0, 1'b0);
    idle(12);
    check("s1_cnt", glog.size(), 1);
    if (glog.size() > 0) check("s1_who", glog[0], 0);
    @(negedge sclk);
    check("s1_idle", busy, 0);

    // all requestors held high from reset
    reset_dut();
    glog.delete();
    for (int i = 0; i < 300 && glog.size() < 5; i++) tick('1, '1, 1'b0, 1'b0);
    check("s2_cnt", 32'(glog.size() >= 5), 1);
    if (glog.size() >= 5) begin
      nrd = 0;
      for (int k = 0; k < 5; k++) begin
        check("s2_order", glog[k], exp_ord[k]);
        if (glog[k] >= NCH) nrd++;
      end
`ifdef ARBIT_WR_PRIO_EN
      check("s2_no_rd", nrd, 0);
`endif
    end
    idle(60);

    // wrong-direction end and end in the grant cycle are ignored
    resp_en = 1'b0; glog.delete();
    tick(2'b10, 2'b00, 1'b0, 1'b0);
    tick(2'b00, 2'b00, 1'b0, 1'b0);
    tick(2'b00, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick(2'b00, 2'b00, 1'b0, 1'b1);
    idle(3);
    @(negedge sclk);
    check("s3_hold", busy, 1);
    check("s3_cnt", glog.size(), 1);
    tick(2'b00, 2'b00, 1'b1, 1'b0);
    tick(2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge sclk);
    check("s3_rel", busy, 0);

    // watchdog: two requests, no end ever returned
    tgap_q.delete();
    tick(2'b01, 2'b10, 1'b0, 1'b0);
    idle(60);
    check("s4_to_cnt", tgap_q.size(), 2);
    for (int k = 0; k < tgap_q.size(); k++) check("s4_gap", tgap_q[k], TO_CYC);

    // reset while waiting for an end
    glog.delete();
    tick(2'b00, 2'b01, 1'b0, 1'b0);
    idle(5);
    check("s5_granted", glog.size(), 1);
    @(posedge sclk);
    #1 rst_n = 1'b0;
    #1 check("s5_rst", {wr_cmd_start, rd_cmd_start, gnt_ch, gnt_wr, busy, timeout_err}, 0);
    repeat (2) @(posedge sclk);
    #1 rst_n = 1'b1;
    resp_en = 1'b1; resp_dly = 2; glog.delete();
    tick(2'b10, 2'b00, 1'b0, 1'b0);
    idle(10);
    check("s5_after", glog.size(), 1);
    if (glog.size() > 0) check("s5_who", glog[0], 1);

    // randomized traffic with random end latency, dropped ends and noise
    reset_dut();
    rand_resp = 1'b1; resp_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < NCH; b++) begin
        wq[b] = ($urandom_range(0, 3) == 0);
        rq[b] = ($urandom_range(0, 3) == 0);
      end
      tick(wq, rq, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0));
    end
    idle(80);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_arbit_rr.md
DDR_ARBIT_RR -- requirements
Module: ddr_arbit_rr

Interface
REQ-001 The block SHALL have parameter NCH, default 2, giving the number of channels; each channel has one write and one read requestor; legal range 1..8.
REQ-002 The block SHALL have parameter TO_CYC, default 1024, giving the watchdog limit in cycles for a granted transfer; 0 disables the watchdog.
REQ-003 The block SHALL have localparam CH_W = max(1, clog2(NCH)).
REQ-004 The block SHALL have one clock, sclk, and a reset, rst_n, that is asynchronous and active-low.
REQ-005 Ports (name, direction, width, meaning):
sclk  in  1  clock.
rst_n  in  1  async active-low reset.
wr_req  in  NCH  per-channel write request, level or pulse.
rd_req  in  NCH  per-channel read request, level or pulse.
wr_end  in  1  write command finished.
rd_end  in  1  read command finished.
wr_cmd_start  out  NCH  one-cycle write start, one-hot.
rd_cmd_start  out  NCH  one-cycle read start, one-hot.
gnt_ch  out  CH_W  granted channel index.
gnt_wr  out  1  granted direction, 1 = write.
busy  out  1  high in GRANT or WAIT_END.
timeout_err  out  1  one-cycle pulse when the watchdog expires.

Function
REQ-006 Each of the 2*NCH requestors SHALL have a pending flag: set on any cycle its req is high, cleared only on the cycle the FSM enters GRANT for it; set has priority over clear only in states other than GRANT-entry for that requestor.
REQ-007 Requestor index SHALL be: 0..NCH-1 = write channel i; NCH..2NCH-1 = read channel i-NCH.
REQ-008 The FSM SHALL have states IDLE, ARBIT, GRANT and WAIT_END, one-hot encoded; an illegal encoding SHALL go to IDLE.
REQ-009 IDLE SHALL go to ARBIT unconditionally after one cycle.
REQ-010 In ARBIT with any flag pending, the block SHALL latch the winner into gnt_ch/gnt_wr and go to GRANT; with none pending it SHALL stay in ARBIT.
REQ-011 Winner selection (default) SHALL be round-robin over all 2*NCH flags, starting the search at last_grant+1 mod 2*NCH; last_grant resets to 2*NCH-1, so index 0 wins first.
REQ-012 GRANT SHALL last exactly one cycle, assert the matching wr_cmd_start or rd_cmd_start bit (registered output), and then go to WAIT_END.
REQ-013 The start pulse SHALL appear 2 cycles after the pending flag is visible in ARBIT; at most one start bit SHALL be high in any cycle.
REQ-014 WAIT_END SHALL return to ARBIT on the end input of the granted direction only; the other direction's end SHALL be ignored.
REQ-015 If the end input is asserted in the same cycle as GRANT, it SHALL be ignored; only an end seen in WAIT_END counts.
REQ-016 A request arriving in any state SHALL be latched and never lost; a re-request by the granted requestor during WAIT_END SHALL re-set its flag.
REQ-017 With TO_CYC>0, a counter SHALL count WAIT_END cycles; on reaching TO_CYC without end, the block SHALL pulse timeout_err for one cycle and go to ARBIT. The counter clears on entering WAIT_END.
REQ-018 gnt_ch and gnt_wr SHALL hold their value outside GRANT/WAIT_END.

Reset
REQ-019 On rst_n low, asynchronously: state=IDLE, all flags=0, last_grant=2*NCH-1, start outputs=0, gnt_ch=0, gnt_wr=0, busy=0, timeout_err=0, watchdog=0.
REQ-020 Reset asserted mid-transfer SHALL abort the transfer with no end required; after release the block SHALL pass through IDLE before arbitrating.

Configuration
REQ-021 With macro ARBIT_WR_PRIO_EN defined, any pending write SHALL beat all reads, with round-robin applied within writes and within reads separately; without the macro, the single unified round-robin of REQ-011 SHALL apply.

Structure
REQ-022 The state encodings and the requestor index-mapping helper SHALL be defined in the shared package ddr_arbit_pkg.
REQ-023 The round-robin search SHALL be a sub-module, rr_pick, with parameter N; inputs are the request vector and the last-grant index, and outputs are the found flag and the winner index.

Verification
REQ-024 Reset release, then wr_req[0] pulsed 1 cycle -> wr_cmd_start[0] pulses once, gnt_wr=1, gnt_ch=0; after wr_end, busy drops.
REQ-025 NCH=2, default build, all 4 reqs held high, end returned 3 cycles after each start -> grant order W0, W1, R0, R1, then W0 again.
REQ-026 Same stimulus as REQ-025 with ARBIT_WR_PRIO_EN defined -> W0, W1, W0, W1...; reads never granted while writes are pending.
REQ-027 TO_CYC=16, write granted, wr_end withheld -> timeout_err pulses 16 cycles after WAIT_END entry; next pending requestor then starts.
REQ-028 rd_end asserted during a write grant and end asserted in the GRANT cycle -> both ignored; only a later wr_end releases the grant.
REQ-029 rst_n pulled low in WAIT_END -> all outputs return to 0 immediately; a post-reset request is served normally.
